// File: rtl/apb_initiator.sv
// -----------------------------------------------------------------------------
// apb_initiator
//   Turns a simple valid/ready command into a single APB transfer and returns
//   the outcome through a valid/ready response. Only one transfer is in flight
//   at a time. An optional ACCESS-phase watchdog ends a transfer whose slave
//   never asserts m_pready and reports it as an error.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | bus quiet, req_ready=1, waiting for req_valid
//   SETUP  | psel=1, penable=0, captured address/control/data on the bus
//   ACCESS | psel=1, penable=1, waiting for m_pready or the watchdog limit
//   RESP   | rsp_valid=1 with stable rdata/err until rsp_ready
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready   command handshake (ready only while IDLE)
//   req_write, req_addr,
//   req_wdata, req_strb   command contents, captured at acceptance
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata, rsp_err    read data (0 for writes/timeouts), slave error/timeout
//   m_p*                  APB initiator-side signals
// -----------------------------------------------------------------------------
module apb_initiator #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WSTRB_WIDTH    = (DATA_WIDTH - 1) / 8 + 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  input  logic [WSTRB_WIDTH-1:0] req_strb,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   rsp_err,
  output logic                   m_psel,
  output logic                   m_penable,
  output logic                   m_pwrite,
  output logic [ADDR_WIDTH-1:0]  m_paddr,
  output logic [DATA_WIDTH-1:0]  m_pwdata,
  output logic [WSTRB_WIDTH-1:0] m_pstrb,
  input  logic [DATA_WIDTH-1:0]  m_prdata,
  input  logic                   m_pready,
  input  logic                   m_pslverr
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  // Counter value during the last permitted ACCESS cycle; the bump out of it
  // would reach TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] TO_LAST =
      (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       wait_cnt_q;
  logic [CNT_W-1:0]       wait_cnt_d;
  logic                   timeout_hit;

  logic                   m_psel_q;
  logic                   m_penable_q;
  logic                   m_pwrite_q;
  logic [ADDR_WIDTH-1:0]  m_paddr_q;
  logic [DATA_WIDTH-1:0]  m_pwdata_q;
  logic [WSTRB_WIDTH-1:0] m_pstrb_q;
  logic                   rsp_valid_q;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q;
  logic                   rsp_err_q;

  // Saturating increment: the counter never wraps, even with the watchdog off.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (wait_cnt_q != CNT_MAX) begin
      wait_cnt_d = wait_cnt_q + CNT_ONE;
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (wait_cnt_q == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      m_psel_q    <= 1'b0;
      m_penable_q <= 1'b0;
      m_pwrite_q  <= 1'b0;
      m_paddr_q   <= '0;
      m_pwdata_q  <= '0;
      m_pstrb_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q    <= SETUP;
            m_psel_q   <= 1'b1;
            m_pwrite_q <= req_write;
            m_paddr_q  <= req_addr;
            m_pwdata_q <= req_wdata;
            m_pstrb_q  <= req_write ? req_strb : '0;
          end
        end
        SETUP: begin
          state_q     <= ACCESS;
          m_penable_q <= 1'b1;
          wait_cnt_q  <= '0;
        end
        ACCESS: begin
          if (m_pready || timeout_hit) begin
            state_q     <= RESP;
            m_psel_q    <= 1'b0;
            m_penable_q <= 1'b0;
            m_pwrite_q  <= 1'b0;
            m_paddr_q   <= '0;
            m_pwdata_q  <= '0;
            m_pstrb_q   <= '0;
            rsp_valid_q <= 1'b1;
            // A ready slave wins over the watchdog in the same cycle.
            if (m_pready) begin
              rsp_rdata_q <= m_pwrite_q ? '0 : m_prdata;
              rsp_err_q   <= m_pslverr;
            end else begin
              rsp_rdata_q <= '0;
              rsp_err_q   <= 1'b1;
            end
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ready derives from registered state only, never from req_valid.
  assign req_ready = (state_q == IDLE);

  assign m_psel    = m_psel_q;
  assign m_penable = m_penable_q;
  assign m_pwrite  = m_pwrite_q;
  assign m_paddr   = m_paddr_q;
  assign m_pwdata  = m_pwdata_q;
  assign m_pstrb   = m_pstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_initiator.sv
module tb_apb_initiator;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        m_psel;
  logic        m_penable;
  logic        m_pwrite;
  logic [31:0] m_paddr;
  logic [31:0] m_pwdata;
  logic [3:0]  m_pstrb;
  logic [31:0] m_prdata;
  logic        m_pready;
  logic        m_pslverr;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  apb_initiator #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .WSTRB_WIDTH   (4),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .m_psel    (m_psel),
    .m_penable (m_penable),
    .m_pwrite  (m_pwrite),
    .m_paddr   (m_paddr),
    .m_pwdata  (m_pwdata),
    .m_pstrb   (m_pstrb),
    .m_prdata  (m_prdata),
    .m_pready  (m_pready),
    .m_pslverr (m_pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_psel"},      m_psel, 0);
    chk({tag, "_penable"},   m_penable, 0);
    chk({tag, "_pwrite"},    m_pwrite, 0);
    chk({tag, "_paddr"},     m_paddr, 0);
    chk({tag, "_pwdata"},    m_pwdata, 0);
    chk({tag, "_pstrb"},     m_pstrb, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
  endtask

  // One complete transfer from IDLE back to IDLE. waits = ACCESS cycles with
  // pready low before the ready cycle; to = slave never answers.
  task automatic run_xfer(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input int waits, input logic [31:0] prdata,
                          input logic slverr, input logic to, input int hold);
    int   n_acc;
    exp_t e;
    logic [3:0] exp_strb;
    n_acc    = to ? TO : waits + 1;
    exp_strb = wr ? strb : 4'h0;
    e.rdata  = (to || wr) ? 32'h0 : prdata;
    e.err    = to ? 1'b1 : slverr;

    chk("start_ready", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_wdata = wdata; req_strb = strb;
    sb.push_back(e);
    tick();
    // SETUP: scramble request inputs to prove the bus uses captured values
    req_valid = 1'b0; req_write = ~wr; req_addr = ~addr;
    req_wdata = ~wdata; req_strb = ~strb;
    chk("setup_psel",    m_psel, 1);
    chk("setup_penable", m_penable, 0);
    chk("setup_paddr",   m_paddr, addr);
    chk("setup_pwrite",  m_pwrite, wr);
    chk("setup_pwdata",  m_pwdata, wdata);
    chk("setup_pstrb",   m_pstrb, exp_strb);
    chk("setup_ready",   req_ready, 0);
    m_pready = 1'b1; m_pslverr = 1'b1;   // must be ignored in SETUP
    tick();
    for (int i = 0; i < n_acc; i++) begin
      chk("acc_psel",    m_psel, 1);
      chk("acc_penable", m_penable, 1);
      chk("acc_paddr",   m_paddr, addr);
      chk("acc_pwrite",  m_pwrite, wr);
      chk("acc_pwdata",  m_pwdata, wdata);
      chk("acc_pstrb",   m_pstrb, exp_strb);
      chk("acc_rspv",    rsp_valid, 0);
      if (!to && i == n_acc - 1) begin
        m_pready = 1'b1; m_prdata = prdata; m_pslverr = slverr;
      end else begin
        m_pready = 1'b0; m_prdata = $urandom; m_pslverr = 1'($urandom_range(0, 1));
      end
      tick();
    end
    // RESP: slave lines now noisy and must be ignored
    m_pready = 1'b1; m_pslverr = 1'b1; m_prdata = 32'hFFFF_FFFF;
    for (int h = 0; h <= hold; h++) begin
      chk("resp_valid",   rsp_valid, 1);
      chk("resp_psel",    m_psel, 0);
      chk("resp_penable", m_penable, 0);
      chk("resp_ready",   req_ready, 0);
      n_cmp++;
      assert (sb.size() > 0) else begin
        n_mis++;
        $error("FAIL sb_empty observed=%0d expected=1", sb.size());
      end
      if (sb.size() > 0) begin
        chk("resp_rdata", rsp_rdata, sb[0].rdata);
        chk("resp_err",   rsp_err, sb[0].err);
      end
      rsp_ready = (h == hold);
      req_valid = (h != hold);           // requests offered in RESP must be ignored
      m_prdata  = $urandom;
      tick();
    end
    if (sb.size() > 0) void'(sb.pop_front());
    rsp_ready = 1'b0; req_valid = 1'b0;
    m_pready = 1'b0; m_pslverr = 1'b0;
    chk_idle("post");
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_strb = '0; rsp_ready = 1'b0;
    m_prdata = '0; m_pready = 1'b0; m_pslverr = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_psel",    m_psel, 0);
    chk("rst_penable", m_penable, 0);
    chk("rst_paddr",   m_paddr, 0);
    chk("rst_pwdata",  m_pwdata, 0);
    chk("rst_pstrb",   m_pstrb, 0);
    chk("rst_pwrite",  m_pwrite, 0);
    chk("rst_rspv",    rsp_valid, 0);
    chk("rst_rdata",   rsp_rdata, 0);
    chk("rst_err",     rsp_err, 0);
    rst = 1'b0;
    tick();
    chk_idle("rel");

    // Slave lines in IDLE without a request do nothing
    m_pready = 1'b1; m_pslverr = 1'b1;
    tick(); tick();
    chk_idle("idle_noise");
    m_pready = 1'b0; m_pslverr = 1'b0;

    // Zero-wait write
    run_xfer(1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 0);
    // Read with 3 wait states (ready lands on the watchdog's last cycle)
    run_xfer(1'b0, 32'h08, 32'h0, 4'hF, 3, 32'h1234_5678, 1'b0, 1'b0, 0);
    // Write with slave error
    run_xfer(1'b1, 32'h20, 32'h1122_3344, 4'h5, 1, 32'hCAFE_F00D, 1'b1, 1'b0, 0);
    // Timeout read
    run_xfer(1'b0, 32'h30, 32'h0, 4'hF, 0, 32'h0BAD_0BAD, 1'b0, 1'b1, 0);
    // Read with error, response held for 5 cycles
    run_xfer(1'b0, 32'h44, 32'h9, 4'h0, 2, 32'h8765_4321, 1'b1, 1'b0, 5);
    // Back-to-back write
    run_xfer(1'b1, 32'h48, 32'hFFFF_0000, 4'h3, 0, 32'h5555_5555, 1'b0, 1'b0, 0);

    // Reset in the middle of ACCESS
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h50; req_strb = 4'hF;
    tick();
    req_valid = 1'b0;
    tick();
    m_pready = 1'b0;
    chk("mid_psel",    m_psel, 1);
    chk("mid_penable", m_penable, 1);
    rst = 1'b1;
    #1;
    chk("arst_psel",    m_psel, 0);
    chk("arst_penable", m_penable, 0);
    chk("arst_paddr",   m_paddr, 0);
    chk("arst_rspv",    rsp_valid, 0);
    sb.delete();
    tick();
    rst = 1'b0; m_pready = 1'b1; m_pslverr = 1'b1;
    tick(); tick();
    chk_idle("after_rst");
    m_pready = 1'b0; m_pslverr = 1'b0;

    // First read after reset completes normally
    run_xfer(1'b0, 32'h0C, 32'h0, 4'hF, 1, 32'h5A5A_1234, 1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/apb_initiator.md
APB_INITIATOR -- requirements
Module: apb_initiator

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter WSTRB_WIDTH, default (DATA_WIDTH-1)/8+1, byte-strobe width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ACCESS-phase wait cycles; 0 disables the timeout.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk  input  1  clock; rst  input  1  reset.
REQ-006 req_valid  input  1  command valid.
REQ-007 req_ready  output  1  command accepted when high together with req_valid.
REQ-008 req_write  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  ADDR_WIDTH  byte address; req_wdata  input  DATA_WIDTH  write data; req_strb  input  WSTRB_WIDTH  write strobes.
REQ-010 rsp_valid  output  1  response valid; rsp_ready  input  1  response consumed.
REQ-011 rsp_rdata  output  DATA_WIDTH  read data; rsp_err  output  1  slave error or timeout.
REQ-012 m_psel, m_penable, m_pwrite  output  1 each; m_paddr  output  ADDR_WIDTH; m_pwdata  output  DATA_WIDTH; m_pstrb  output  WSTRB_WIDTH.
REQ-013 m_prdata  input  DATA_WIDTH; m_pready  input  1; m_pslverr  input  1.

Function
REQ-014 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; one transfer in flight at most.
REQ-015 req_ready SHALL be 1 only in IDLE (registered state, no combinational path from req_valid).
REQ-016 IDLE: req_valid=1 -> capture write/addr/wdata/strb into registers, go to SETUP next cycle.
REQ-017 SETUP (exactly one cycle): m_psel=1, m_penable=0, address/control/data driven from captured registers -> ACCESS.
REQ-018 ACCESS: m_psel=1, m_penable=1; m_paddr, m_pwrite, m_pwdata, m_pstrb SHALL hold stable until exit.
REQ-019 ACCESS with m_pready=1 -> sample m_prdata (reads only; writes load 0) and m_pslverr into rsp registers, go to RESP.
REQ-020 m_pstrb SHALL be driven 0 for reads regardless of req_strb.
REQ-021 Outside SETUP/ACCESS m_psel and m_penable SHALL be 0; m_paddr/m_pwdata/m_pstrb/m_pwrite SHALL be 0 in IDLE.
REQ-022 Wait counter SHALL clear on SETUP->ACCESS and increment each ACCESS cycle with m_pready=0; width $clog2(TIMEOUT_CYCLES+1), minimum 1, no wrap.
REQ-023 TIMEOUT_CYCLES>0 and counter reaching TIMEOUT_CYCLES with m_pready=0 -> exit ACCESS, rsp_err=1, rsp_rdata=0, go to RESP; m_pready in the same cycle as the limit wins (normal completion).
REQ-024 RESP: rsp_valid=1, rsp_rdata/rsp_err stable; rsp_ready=1 -> IDLE next cycle; no new request accepted in the RESP cycle.
REQ-025 Minimum latency: accept cycle N, SETUP N+1, ACCESS N+2, rsp_valid N+3 (pready=1 on first ACCESS cycle).
REQ-026 m_pready/m_pslverr SHALL be ignored outside ACCESS.

Reset
REQ-027 rst=1 SHALL immediately (asynchronously) force IDLE, counter 0, all APB outputs 0, rsp_valid=0, rsp_err=0, rsp_rdata=0; req_ready=1 after release.
REQ-028 rst asserted mid-transfer SHALL abandon the transfer with no response generated; first request after release proceeds normally.

Verification
REQ-029 Write addr=0x10, wdata=0xA5A5A5A5, strb=0xF, pready=1 immediately -> SETUP/ACCESS one cycle each with stable bus, rsp_valid at N+3, rsp_err=0.
REQ-030 Read addr=0x08, slave pready after 3 wait cycles, prdata=0x12345678 -> m_pstrb=0 throughout, rsp_rdata=0x12345678, rsp_err=0.
REQ-031 Write with m_pslverr=1 at pready -> rsp_err=1, rsp_rdata=0.
REQ-032 TIMEOUT_CYCLES=4, pready held 0 -> ACCESS lasts 4 cycles, psel/penable drop, rsp_err=1, rsp_rdata=0.
REQ-033 rsp_ready held 0 for 5 cycles -> rsp_valid/data stable, req_ready=0; back-to-back requests keep APB idle between transfers.
REQ-034 rst pulsed during ACCESS -> psel/penable 0 in the same cycle, no rsp_valid; next read completes correctly.
